dram_port_arbiter: RTL
======================

# dram_port_arbiter

Round-robin arbiter that shares the single-port data SRAM (sky130 32x512, port 0) between the core's data port and the caravel Wishbone slave port. It replaces the static LA-selected data RAM mux, so the host can read and write data memory while the core runs. It sits between the Wishbone address decoder (slave 1) and the data SRAM macro. It sequences every access as command → SRAM clock edge → response.

## Interface
- BASE_ADDR, 32'h3000_4000, byte base address of the data RAM window (core side decode)
- RAM_ADDR_WIDTH_WORDS, 9, SRAM word-address width; window size = 4·2^RAM_ADDR_WIDTH_WORDS bytes
- wb_clk_i  in  1  sole clock; all state on its rising edge
- rstn  in  1  asynchronous, active-low reset
- wb_excl  in  1  1 = Wishbone-exclusive mode: core requests are held off, never granted
- cpu_stb  in  1  core request strobe, held until ack or err
- cpu_we  in  4  byte write enables; 0 = read
- cpu_addr  in  32  core byte address
- cpu_wdata  in  32  core write data
- cpu_rdata  out  32  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion
- cpu_err  out  1  one-cycle error: address outside window
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone request qualifiers
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address, already decoded upstream
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle completion
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1
- ram_clk0  out  1  = wb_clk_i
- ram_csb0, ram_web0  out  1  active-low chip select / write enable
- ram_wmask0  out  4  byte mask
- ram_addr0  out  RAM_ADDR_WIDTH_WORDS  word address = addr[RAM_ADDR_WIDTH_WORDS+1:2]
- ram_din0  out  32  write data
- ram_dout0  in  32  SRAM read data, valid the cycle after the capturing edge

## Operation
- Requests: cpu_req = cpu_stb & ~wb_excl; wb_req = wbs_stb_i & wbs_cyc_i.
- cpu_hit = (cpu_addr & ~(window_size-1)) == BASE_ADDR. Wishbone addresses are not range-checked; only the word bits are used.
- FSM states:
  - IDLE: with no request, stay. With cpu_req & ~cpu_hit as the winner → ERR. Otherwise latch the winner, its address, wdata and mask → CMD.
  - CMD: ram_csb0=0; ram_web0=0 iff write; SRAM captures at the end of this cycle → RESP.
  - RESP: winner's ack=1, rdata = ram_dout0 → IDLE.
  - ERR: cpu_err=1 for one cycle, no SRAM access → IDLE.
- Arbitration: if only one requester is active, it wins. If both are active, the one not granted last wins.
  - last_grant updates only on entry to CMD. ERR does not update it.
  - last_grant resets to WB, so the first tie goes to the core.
- Write definition:
  - Core: write = |cpu_we; wmask = cpu_we.
  - Wishbone: write = wbs_we_i; wmask = wbs_sel_i.
  - Reads drive wmask=4'hF.
- Abort: if the winner's stb (or cyc) drops during CMD or RESP, the SRAM access still completes, but ack is suppressed.
- wb_excl rising while the core holds the grant does not abort the in-flight access.
- Non-granted outputs: ack, err and rdata are 0 for the port not being served.

## Timing
- Reset values: ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, all acks/err=0, rdata outputs=0, state=IDLE, last_grant=WB.
- Reset assertion mid-access returns everything to reset values immediately. No ack is produced, and the SRAM write is not guaranteed.
- Latency:
  - Request sampled in cycle 0 (IDLE) → csb0 low in cycle 1 → ack in cycle 2.
  - Out-of-range core request → err in cycle 1.
- Throughput: one access per 3 cycles. A loser waits at most one full access (3 cycles) plus its own 3.
- All SRAM control and data outputs are registered. Ack, err and rdata decode from state and pass ram_dout0 through combinationally.
- The requester must deassert stb in the cycle after ack. A stb still high in the IDLE cycle after ack is treated as a new request.

## Test plan
- Core write then read: cpu_we=4'hF, addr 0x3000_4010, wdata 0xDEADBEEF → csb0=0, web0=0, addr0=4 in cycle 1, ack in cycle 2. Read of the same address → cpu_rdata=0xDEADBEEF in cycle 2.
- Byte write via Wishbone: sel=4'b0010, dat 0x0000AB00 over 0x11223344 → wmask0=4'b0010; a later read returns 0x1122AB44.
- Simultaneous requests from reset: core granted first. Held requests alternate WB, core, WB. Each ack is 3 cycles apart, and no cycle has both acks.
- Core addr 0x3000_4800 (one past the window) → cpu_err=1 in cycle 1, csb0 never low, last_grant unchanged.
- wb_excl=1 with a core request pending for 20 cycles → no core grant. Wishbone accesses still complete. wb_excl→0 → core ack 2 cycles after the next IDLE.
- rstn pulsed low during CMD → outputs at reset values in the same cycle, no ack. After release, a new request completes normally.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing the data SRAM port 0 between the core
// and the caravel Wishbone slave; each access is CMD -> SRAM edge -> RESP.
module dram_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_4000,
  parameter int RAM_ADDR_WIDTH_WORDS = 9
) (
  input  logic        wb_clk_i,
  input  logic        rstn,
  input  logic        wb_excl,
  input  logic        cpu_stb,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ram_clk0,
  output logic        ram_csb0,
  output logic        ram_web0,
  output logic [3:0]  ram_wmask0,
  output logic [RAM_ADDR_WIDTH_WORDS-1:0] ram_addr0,
  output logic [31:0] ram_din0,
  input  logic [31:0] ram_dout0
);

  localparam int AW = RAM_ADDR_WIDTH_WORDS;
  localparam logic [31:0] WIN_MASK =
    ~((32'd4 << AW) - 32'd1);

  typedef enum logic [1:0] {
    IDLE, CMD, RESP, ERR
  } state_t;

  state_t state;
  logic   last_cpu;
  logic   owner_cpu;
  logic   aborted;

  logic cpu_req;
  logic wb_req;
  logic cpu_hit;
  logic cpu_wins;
  logic serve_live;
  logic resp_ok;
  logic unused_bits;

  assign cpu_req  = cpu_stb & ~wb_excl;
  assign wb_req   = wbs_stb_i & wbs_cyc_i;
  assign cpu_hit  = (cpu_addr & WIN_MASK) == BASE_ADDR;
  // A tie goes to whoever was not granted last
  assign cpu_wins = cpu_req & (~wb_req | ~last_cpu);

  assign serve_live = owner_cpu ? cpu_stb : wb_req;

  always_ff @(posedge wb_clk_i or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_cpu   <= 1'b0;
      owner_cpu  <= 1'b0;
      aborted    <= 1'b0;
      ram_csb0   <= 1'b1;
      ram_web0   <= 1'b1;
      ram_wmask0 <= 4'h0;
      ram_addr0  <= '0;
      ram_din0   <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          aborted <= 1'b0;
          if (cpu_wins) begin
            if (!cpu_hit) begin
              state <= ERR;
            end else begin
              state      <= CMD;
              owner_cpu  <= 1'b1;
              last_cpu   <= 1'b1;
              ram_csb0   <= 1'b0;
              ram_web0   <= ~|cpu_we;
              ram_wmask0 <= (|cpu_we) ? cpu_we : 4'hF;
              ram_addr0  <= cpu_addr[AW+1:2];
              ram_din0   <= cpu_wdata;
            end
          end else if (wb_req) begin
            state      <= CMD;
            owner_cpu  <= 1'b0;
            last_cpu   <= 1'b0;
            ram_csb0   <= 1'b0;
            ram_web0   <= ~wbs_we_i;
            ram_wmask0 <= wbs_we_i ? wbs_sel_i : 4'hF;
            ram_addr0  <= wbs_adr_i[AW+1:2];
            ram_din0   <= wbs_dat_i;
          end
        end
        CMD: begin
          ram_csb0 <= 1'b1;
          ram_web0 <= 1'b1;
          // Requester gave up; finish the SRAM cycle but drop the ack
          if (!serve_live) aborted <= 1'b1;
          state <= RESP;
        end
        RESP: state <= IDLE;
        ERR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_ok   = (state == RESP) & ~aborted & serve_live;
  assign cpu_ack   = resp_ok & owner_cpu;
  assign wbs_ack_o = resp_ok & ~owner_cpu;
  assign cpu_err   = (state == ERR);
  assign cpu_rdata = cpu_ack ? ram_dout0 : 32'h0;
  assign wbs_dat_o = wbs_ack_o ? ram_dout0 : 32'h0;
  assign ram_clk0  = wb_clk_i;

  assign unused_bits = ^{cpu_addr[1:0], wbs_adr_i[1:0],
                         wbs_adr_i[31:AW+2]};

endmodule
